// File: rtl/cal_pkg.sv
// Shared types and helpers for the calibration table builder.
// State encoding, pixel/channel widths and the lit decision used by the RMW pipe.
package cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_FRAME,
        ACCUM,
        DRAIN,
        DONE
    } cal_state_t;

    // Pixel format: NUM_CH channels of CH_W bits, channel 0 in the LSBs.
    localparam int CAL_NUM_CH = 3;
    localparam int CAL_CH_W   = 8;
    localparam int CAL_SUM_W  = CAL_CH_W + $clog2(CAL_NUM_CH);
    localparam int CAL_PIX_W  = CAL_NUM_CH * CAL_CH_W;

    // A pixel is lit when the unsigned channel sum reaches the threshold.
    // SUM_W carries the extra bits needed so the sum can never wrap.
    function automatic logic lit_f(input logic [CAL_PIX_W-1:0] data,
                                   input logic [CAL_SUM_W-1:0] thr);
        logic [CAL_SUM_W-1:0] sum;
        sum = '0;
        for (int c = 0; c < CAL_NUM_CH; c++) begin
            sum = sum + CAL_SUM_W'(data[c*CAL_CH_W +: CAL_CH_W]);
        end
        return (sum >= thr);
    endfunction

endpackage

// File: rtl/cal_rmw_pipe.sv
// Two-stage read/shift/write pipe for the calibration table.
// Beat accepted in cycle 0 reads the table, the shifted entry is formed in
// cycle 1 and written in cycle 2. The two most recent writes are forwarded so
// back-to-back beats to one address chain correctly.
// With CAL_LIT_MASK_EN the entry MSB is a sticky "ever lit" flag.
module cal_rmw_pipe
    import cal_pkg::*;
#(
    parameter int NUM_PIXELS = 64800,
    parameter int ID_BITS    = 11,
    parameter int AW         = $clog2(NUM_PIXELS),
    parameter int EW         = ID_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 acc_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [CAL_PIX_W-1:0] data_i,
    input  logic [CAL_SUM_W-1:0] thr_i,
    output logic [AW-1:0]        raddr_o,
    input  logic [EW-1:0]        rdata_i,
    output logic                 we_o,
    output logic [AW-1:0]        waddr_o,
    output logic [EW-1:0]        wdata_o,
    output logic                 busy_o
);

    logic          inr_p0;
    logic          vld_p1_q, inr_p1_q, lit_p1_q;
    logic [AW-1:0] addr_p1_q;
    logic          vld_p2_q, inr_p2_q;
    logic [AW-1:0] addr_p2_q;
    logic [EW-1:0] wdata_p2_q;
    logic          vld_p3_q;
    logic [AW-1:0] addr_p3_q;
    logic [EW-1:0] wdata_p3_q;
    logic [EW-1:0] old_d, wdata_d;

    // Out-of-range beats still flow through the pipe but never write.
    assign inr_p0  = (int'(addr_i) < NUM_PIXELS);
    assign raddr_o = addr_i;

    // Valid chain; p3 marks the write that has just landed in the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else if (flush_i) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            vld_p1_q <= acc_i;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q & inr_p2_q;
        end
    end

    // Data stages (no reset; qualified by the valid chain).
    always_ff @(posedge clk) begin
        // p0 -> p1
        addr_p1_q  <= addr_i;
        inr_p1_q   <= inr_p0;
        lit_p1_q   <= lit_f(data_i, thr_i);
        // p1 -> p2
        addr_p2_q  <= addr_p1_q;
        inr_p2_q   <= inr_p1_q;
        wdata_p2_q <= wdata_d;
        // p2 -> p3
        addr_p3_q  <= addr_p2_q;
        wdata_p3_q <= wdata_p2_q;
    end

    // Pick the freshest copy of the entry: pending write, just-written, then table.
    always_comb begin
        old_d = rdata_i;
        if (vld_p3_q && (addr_p3_q == addr_p1_q)) begin
            old_d = wdata_p3_q;
        end
        if (vld_p2_q && inr_p2_q && (addr_p2_q == addr_p1_q)) begin
            old_d = wdata_p2_q;
        end
`ifdef CAL_LIT_MASK_EN
        wdata_d = {old_d[ID_BITS] | lit_p1_q,
                   (old_d[ID_BITS-1:0] << 1) | ID_BITS'(lit_p1_q)};
`else
        wdata_d = (old_d << 1) | EW'(lit_p1_q);
`endif
    end

    assign we_o    = vld_p2_q & inr_p2_q;
    assign waddr_o = addr_p2_q;
    assign wdata_o = wdata_p2_q;
    assign busy_o  = vld_p1_q | vld_p2_q;

endmodule

// File: rtl/cal_table_builder.sv
// Pixel -> LED-ID calibration table builder.
// Clears the table, then captures ID_BITS bit-planes (MSB first) from the
// pixel stream, shifting one lit bit per plane into each pixel's entry.
// Optional feature macro: CAL_LIT_MASK_EN (sticky lit flag per entry; pixels
// never lit read back as all-ones).
module cal_table_builder
    import cal_pkg::*;
#(
    parameter  int NUM_PIXELS = 64800,
    parameter  int ID_BITS    = 11,
    localparam int AW         = $clog2(NUM_PIXELS),
    localparam int BW         = $clog2(ID_BITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CAL_SUM_W-1:0] threshold,
    input  logic                 id_frame_valid,
    output logic                 advance_id,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [AW-1:0]        pix_addr,
    input  logic [CAL_PIX_W-1:0] pix_data,
    input  logic                 pix_last,
    output logic [BW-1:0]        bit_index,
    output logic                 busy,
    output logic                 done,
    input  logic [AW-1:0]        rd_addr,
    output logic [ID_BITS-1:0]   rd_data
);

`ifdef CAL_LIT_MASK_EN
    localparam int EW = ID_BITS + 1;
`else
    localparam int EW = ID_BITS;
`endif

    cal_state_t   state_q;
    logic [AW-1:0] clr_cnt_q;
    logic [BW-1:0] bit_idx_q;
    logic          adv_q, rdy_q, busy_q, done_q;
    logic          acc, pipe_busy, pipe_we;
    logic [AW-1:0] pipe_raddr, pipe_waddr;
    logic [EW-1:0] pipe_wdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [EW-1:0] ram_wdata;
    logic [EW-1:0] mem [NUM_PIXELS];
    logic [EW-1:0] a_rdata_q, b_rdata_q;
    logic [ID_BITS-1:0] rd_data_q;

    assign acc = pix_valid & rdy_q;

    // Sequencer: clear, per-plane wait/accumulate, drain, done; abort wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            bit_idx_q <= '0;
            adv_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            adv_q <= 1'b0;
            if (abort) begin
                state_q   <= IDLE;
                bit_idx_q <= '0;
                rdy_q     <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q   <= CLEAR;
                            clr_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        if (clr_cnt_q == AW'(NUM_PIXELS - 1)) begin
                            state_q   <= WAIT_FRAME;
                            bit_idx_q <= BW'(ID_BITS - 1);
                            adv_q     <= 1'b1;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 1'b1;
                        end
                    end
                    WAIT_FRAME: begin
                        if (id_frame_valid) begin
                            state_q <= ACCUM;
                            rdy_q   <= 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (acc && pix_last) begin
                            rdy_q <= 1'b0;
                            if (bit_idx_q == '0) begin
                                state_q <= DRAIN;
                            end else begin
                                bit_idx_q <= bit_idx_q - 1'b1;
                                adv_q     <= 1'b1;
                                state_q   <= WAIT_FRAME;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!pipe_busy) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    cal_rmw_pipe #(
        .NUM_PIXELS(NUM_PIXELS),
        .ID_BITS   (ID_BITS),
        .AW        (AW),
        .EW        (EW)
    ) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(abort),
        .acc_i  (acc),
        .addr_i (pix_addr),
        .data_i (pix_data),
        .thr_i  (threshold),
        .raddr_o(pipe_raddr),
        .rdata_i(a_rdata_q),
        .we_o   (pipe_we),
        .waddr_o(pipe_waddr),
        .wdata_o(pipe_wdata),
        .busy_o (pipe_busy)
    );

    // Clear sweep owns the write port while in CLEAR; the pipe is empty then.
    always_comb begin
        ram_we    = pipe_we;
        ram_waddr = pipe_waddr;
        ram_wdata = pipe_wdata;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = '0;
        end
    end

    // Table storage: read-first, RMW side and independent external read side.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        a_rdata_q <= mem[pipe_raddr];
        b_rdata_q <= mem[rd_addr];
    end

    // Second external read stage, mapping never-lit entries when the mask is on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
`ifdef CAL_LIT_MASK_EN
            rd_data_q <= b_rdata_q[ID_BITS] ? b_rdata_q[ID_BITS-1:0] : '1;
`else
            rd_data_q <= b_rdata_q;
`endif
        end
    end

    assign advance_id = adv_q;
    assign pix_ready  = rdy_q;
    assign bit_index  = bit_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_data    = rd_data_q;

endmodule
